// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
//   Multi-cycle control FSM for the 18-bit CPU datapath. It runs each
//   instruction through fetch, decode, execute, memory and writeback. It holds
//   the instruction register and the CMP flag register. It drives the
//   instruction/data memory request handshakes, the PC update strobe (exactly
//   one per instruction) and the register-file write strobe.
//
//   Optional feature: define RETIRE_COUNT_EN to add the retired[31:0]
//   instruction counter output. This counter advances on every pc_write cycle.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   0 IDLE      | after reset, moves to FETCH on the next cycle
//   1 FETCH     | imem_req held until imem_ack, which loads ir
//   2 DECODE    | one cycle, alu_ctrl settles from ir
//   3 EXECUTE   | ALU ops go on to WRITEBACK; CMP/jumps/NOP retire here
//   4 MEMORY    | dmem_req held until dmem_ack; ST retires here
//   5 WRITEBACK | reg_write + pc_write, then back to FETCH
//   7 FAULT     | ack timeout; every strobe is quiet until reset
//
// Ports
//   clk_sys, rst          clock and synchronous active-high reset
//   imem_req/ack/rdata    instruction fetch handshake
//   dmem_req/we/addr/ack  data memory handshake, addr = ir[9:0]
//   alu_below/equal/above ALU compare results, latched into flags by CMP
//   ir                    instruction register
//   alu_ctrl, alu_imm_sel ALU operation select and immediate source select
//   reg_write, mem_to_reg register-file write strobe and writeback source
//   pc_write, pc_jump     PC update strobe; with pc_jump the PC loads jump_addr
//   jump_addr             ir[13:0]
//   flags                 {below,equal,above} latched by the last CMP
//   fault                 high while in FAULT
//   state                 current FSM encoding
//   retired               (RETIRE_COUNT_EN only) retired instruction count

module multicycle_sequencer #(
   parameter int IW          = 18,
   parameter int PCW         = 14,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic           clk_sys,
   input  logic           rst,
   output logic           imem_req,
   input  logic           imem_ack,
   input  logic [IW-1:0]  imem_rdata,
   output logic           dmem_req,
   output logic           dmem_we,
   output logic [9:0]     dmem_addr,
   input  logic           dmem_ack,
   input  logic           alu_below,
   input  logic           alu_equal,
   input  logic           alu_above,
   output logic [IW-1:0]  ir,
   output logic [1:0]     alu_ctrl,
   output logic           alu_imm_sel,
   output logic           reg_write,
   output logic           mem_to_reg,
   output logic           pc_write,
   output logic           pc_jump,
   output logic [PCW-1:0] jump_addr,
   output logic [2:0]     flags,
   output logic           fault,
`ifdef RETIRE_COUNT_EN
   output logic [31:0]    retired,
`endif
   output logic [2:0]     state
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_EXECUTE   = 3'd3,
      S_MEMORY    = 3'd4,
      S_WRITEBACK = 3'd5,
      S_FAULT     = 3'd7
   } state_t;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_ADDI = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_ANDI = 4'h3;
   localparam logic [3:0] OP_NAND = 4'h4;
   localparam logic [3:0] OP_NOR  = 4'h5;
   localparam logic [3:0] OP_LD   = 4'h6;
   localparam logic [3:0] OP_ST   = 4'h7;
   localparam logic [3:0] OP_JMP  = 4'h8;
   localparam logic [3:0] OP_CMP  = 4'h9;
   localparam logic [3:0] OP_JE   = 4'hA;
   localparam logic [3:0] OP_JA   = 4'hB;
   localparam logic [3:0] OP_JB   = 4'hC;
   localparam logic [3:0] OP_JAE  = 4'hD;
   localparam logic [3:0] OP_JBE  = 4'hE;

   // The ack wait timer is a down-counter. It loads ACK_TIMEOUT-1 on entry to
   // FETCH or MEMORY, and it hits the fault condition at zero. That gives
   // exactly ACK_TIMEOUT waiting cycles.
   localparam int CW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [CW-1:0] WAIT_LOAD = (ACK_TIMEOUT > 0) ? CW'(ACK_TIMEOUT - 1) : '0;

   state_t        state_q, state_nxt;
   logic [IW-1:0] ir_q;
   logic [2:0]    flags_q;
   logic [CW-1:0] wait_q;
   logic [3:0]    opc;
   logic          ir_load;
   logic          flags_load;
   logic          wait_tc;
   logic          enter_wait;
   logic          taken;

   assign opc     = ir_q[IW-1:IW-4];
   assign wait_tc = (ACK_TIMEOUT != 0) && (wait_q == '0);

   // Jumps look only at the latched flags {below,equal,above}, never at the
   // live ALU compare inputs.
   always_comb begin
      taken = 1'b0;
      case (opc)
         OP_JMP:  taken = 1'b1;
         OP_JE:   taken = flags_q[1];
         OP_JA:   taken = flags_q[0];
         OP_JB:   taken = flags_q[2];
         OP_JAE:  taken = flags_q[0] | flags_q[1];
         OP_JBE:  taken = flags_q[2] | flags_q[1];
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt   = state_q;
      ir_load     = 1'b0;
      flags_load  = 1'b0;
      imem_req    = 1'b0;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      reg_write   = 1'b0;
      mem_to_reg  = 1'b0;
      pc_write    = 1'b0;
      pc_jump     = 1'b0;
      alu_ctrl    = 2'b00;
      alu_imm_sel = 1'b0;
      fault       = 1'b0;

      case (state_q)
         S_IDLE: state_nxt = S_FETCH;
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               ir_load   = 1'b1;
               state_nxt = S_DECODE;
            end else if (wait_tc) begin
               state_nxt = S_FAULT;
            end
         end
         S_DECODE: state_nxt = S_EXECUTE;
         S_EXECUTE: begin
            case (opc)
               OP_ADD, OP_ADDI, OP_AND, OP_ANDI, OP_NAND, OP_NOR:
                  state_nxt = S_WRITEBACK;
               OP_LD, OP_ST:
                  state_nxt = S_MEMORY;
               OP_CMP: begin
                  flags_load = 1'b1;
                  pc_write   = 1'b1;
                  state_nxt  = S_FETCH;
               end
               default: begin
                  // Jumps and NOP. NOP never counts as taken.
                  pc_write  = 1'b1;
                  pc_jump   = taken;
                  state_nxt = S_FETCH;
               end
            endcase
         end
         S_MEMORY: begin
            dmem_req = 1'b1;
            dmem_we  = (opc == OP_ST);
            if (dmem_ack) begin
               if (opc == OP_ST) begin
                  pc_write  = 1'b1;
                  state_nxt = S_FETCH;
               end else begin
                  state_nxt = S_WRITEBACK;
               end
            end else if (wait_tc) begin
               state_nxt = S_FAULT;
            end
         end
         S_WRITEBACK: begin
            reg_write  = 1'b1;
            mem_to_reg = (opc == OP_LD);
            pc_write   = 1'b1;
            state_nxt  = S_FETCH;
         end
         S_FAULT: fault = 1'b1;
         default: state_nxt = S_IDLE;
      endcase

      if (state_q inside {S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK}) begin
         case (opc)
            OP_AND, OP_ANDI: alu_ctrl = 2'b01;
            OP_NAND:         alu_ctrl = 2'b10;
            OP_NOR:          alu_ctrl = 2'b11;
            default:         alu_ctrl = 2'b00;
         endcase
         alu_imm_sel = (opc == OP_ADDI) || (opc == OP_ANDI);
      end

      // Reset abandons the current instruction in the same cycle, so no
      // strobe may escape while it is asserted.
      if (rst) begin
         ir_load     = 1'b0;
         flags_load  = 1'b0;
         imem_req    = 1'b0;
         dmem_req    = 1'b0;
         dmem_we     = 1'b0;
         reg_write   = 1'b0;
         mem_to_reg  = 1'b0;
         pc_write    = 1'b0;
         pc_jump     = 1'b0;
         alu_ctrl    = 2'b00;
         alu_imm_sel = 1'b0;
         fault       = 1'b0;
      end
   end

   assign enter_wait = ((state_nxt == S_FETCH)  && (state_q != S_FETCH)) ||
                       ((state_nxt == S_MEMORY) && (state_q != S_MEMORY));

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         state_q <= S_IDLE;
         ir_q    <= '0;
         flags_q <= '0;
         wait_q  <= '0;
      end else begin
         state_q <= state_nxt;
         if (ir_load)
            ir_q <= imem_rdata;
         if (flags_load)
            flags_q <= {alu_below, alu_equal, alu_above};
         if (enter_wait)
            wait_q <= WAIT_LOAD;
         else if (wait_q != '0)
            wait_q <= wait_q - 1'b1;
      end
   end

`ifdef RETIRE_COUNT_EN
   always_ff @(posedge clk_sys) begin
      if (rst)
         retired <= '0;
      else if (pc_write)
         retired <= retired + 32'd1;
   end
`endif

   assign ir        = ir_q;
   assign flags     = flags_q;
   assign jump_addr = ir_q[PCW-1:0];
   assign dmem_addr = ir_q[9:0];
   assign state     = state_q;

endmodule
